// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Saturating mode is selected at build time with the SUB_SAT_EN macro.
package sub_pkg;
  localparam int unsigned SUB_WIDTH_DEF = 8;
  localparam int unsigned SUB_CNT_W     = $clog2(SUB_WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sub_state_e;
endpackage

// File: rtl/sub_serial_full_sub.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow out.
module full_sub (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);
  always_comb begin
    d_o    = a_i ^ b_i ^ bin_i;
    bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
  end
endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor D = A - B, one bit per cycle, valid/ready on both sides.
// Define SUB_SAT_EN to clamp a borrowing result to {1, 0...0}.
module sub_serial
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   D
);
  localparam int unsigned CW = $clog2(WIDTH);

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [WIDTH:0]   dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d;
  logic             dbit, bout, last_bit;

  full_sub u_fs (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .bin_i (bor_q),
    .d_o   (dbit),
    .bout_o(bout)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    diff_d    = diff_q;
    dout_d    = dout_q;
    cnt_d     = cnt_q;
    bor_d     = bor_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          bor_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        bor_d  = bout;
        // Difference bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
        diff_d = WIDTH'({dbit, diff_q} >> 1);
        cnt_d  = cnt_q + CW'(1);
        if (last_bit) begin
`ifdef SUB_SAT_EN
          dout_d = bout ? {1'b1, WIDTH'(0)} : {bout, diff_d};
`else
          dout_d = {bout, diff_d};
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      dout_q <= '0;
      cnt_q  <= '0;
      bor_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      diff_q <= diff_d;
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
      bor_q  <= bor_d;
    end
  end

  assign D = dout_q;
endmodule
